game_countdown_timer: RTL



---
 rtl/game_timer_pkg.sv | 33 +++
 rtl/game_countdown_timer_sec_to_bcd.sv | 26 ++
 rtl/game_countdown_timer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_timer_pkg.sv
// ----------------------------------------------------------------------------
// game_timer_pkg : shared types and constants for the HUD round timer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package game_timer_pkg;

   localparam int CNT_W   = 10;
   localparam int MAX_SEC = 599;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SEC);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_e;

   // Sum is formed one bit wider so the clamp sees the true overflowed value.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, MAX_CNT})
         return MAX_CNT;
      else
         return sum[CNT_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_countdown_timer_sec_to_bcd.sv
// ----------------------------------------------------------------------------
// sec_to_bcd : binary seconds (0..599) to M:SS BCD digits, combinational
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sec_to_bcd
   import game_timer_pkg::*;
(
   input  logic [CNT_W-1:0] sec_i,
   output logic [3:0]       min_ones_o,
   output logic [3:0]       sec_tens_o,
   output logic [3:0]       sec_ones_o
);

   logic [5:0] secs_w;

   // Input never exceeds 599, so the narrowing casts lose nothing.
   assign min_ones_o = 4'(sec_i / CNT_W'(60));
   assign secs_w     = 6'(sec_i % CNT_W'(60));
   assign sec_tens_o = 4'(secs_w / 6'd10);
   assign sec_ones_o = 4'(secs_w % 6'd10);

endmodule

`default_nettype wire

// File: rtl/game_countdown_timer.sv
// ----------------------------------------------------------------------------
// game_countdown_timer : M:SS round timer with pause, restart and bonus time
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module game_countdown_timer
   import game_timer_pkg::*;
#(
   parameter int START_MIN = 2,
   parameter int START_SEC = 0,
   parameter int BONUS_SEC = 10,
   parameter int WARN_SEC  = 10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       one_sec_i,
   input  logic       start_i,
   input  logic       pause_toggle_i,
   input  logic       bonus_add_i,
   output logic [3:0] min_ones_o,
   output logic [3:0] sec_tens_o,
   output logic [3:0] sec_ones_o,
   output logic       running_o,
   output logic       warning_o,
   output logic       time_up_o,
   output logic       expired_o
);

   localparam logic [CNT_W-1:0] INIT  = CNT_W'(START_MIN * 60 + START_SEC);
   localparam logic [CNT_W-1:0] BONUS = CNT_W'(BONUS_SEC);
   localparam logic [CNT_W-1:0] WARN  = CNT_W'(WARN_SEC);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   if (START_MIN < 0 || START_MIN > 9) begin : g_chk_min
      $error("START_MIN out of range 0..9");
   end
   if (START_SEC < 0 || START_SEC > 59) begin : g_chk_sec
      $error("START_SEC out of range 0..59");
   end
   if (START_MIN * 60 + START_SEC < 1 || START_MIN * 60 + START_SEC > MAX_SEC) begin : g_chk_init
      $error("initial time must be 1..599 seconds");
   end
   if (BONUS_SEC < 1 || BONUS_SEC > MAX_SEC) begin : g_chk_bonus
      $error("BONUS_SEC out of range 1..599");
   end
   if (WARN_SEC < 0 || WARN_SEC > 598) begin : g_chk_warn
      $error("WARN_SEC out of range 0..598");
   end

   timer_state_e     state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             time_up_q, time_up_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         count_q   <= INIT;
         time_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         time_up_q <= time_up_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      time_up_d = 1'b0;
      if (start_i) begin
         state_d = ST_RUNNING;
         count_d = INIT;
      end else begin
         case (state_q)
            ST_RUNNING: begin
               // count is at least 1 while running, so the decrement cannot wrap
               if (one_sec_i && bonus_add_i)
                  count_d = sat_add(count_q - ONE, BONUS);
               else if (one_sec_i)
                  count_d = count_q - ONE;
               else if (bonus_add_i)
                  count_d = sat_add(count_q, BONUS);
               if (pause_toggle_i)
                  state_d = ST_PAUSED;
               if (one_sec_i && !bonus_add_i && count_q == ONE) begin
                  state_d   = ST_EXPIRED;
                  time_up_d = 1'b1;
               end
            end
            ST_PAUSED: begin
               if (bonus_add_i)
                  count_d = sat_add(count_q, BONUS);
               if (pause_toggle_i)
                  state_d = ST_RUNNING;
            end
            ST_EXPIRED: begin
               count_d = '0;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign running_o = (state_q == ST_RUNNING);
   assign expired_o = (state_q == ST_EXPIRED);
   assign warning_o = (state_q == ST_RUNNING || state_q == ST_PAUSED) && (count_q <= WARN);
   assign time_up_o = time_up_q;

   sec_to_bcd u_sec_to_bcd (
      .sec_i      (count_q),
      .min_ones_o (min_ones_o),
      .sec_tens_o (sec_tens_o),
      .sec_ones_o (sec_ones_o)
   );

endmodule

`default_nettype wire
